// File: rtl/beep_sched_if.sv
// rtl/beep_sched_if.sv - request/status bundle between the game FSM and the buzzer scheduler
//
// Purpose: groups the sound-request inputs and buzzer/status outputs of
// beep_sched so they travel as one port.
// Signals:
//   mute       master->slave  synchronous silence/flush
//   req[3:0]   master->slave  one-cycle request pulses, bit k = sound id k
//   beep       slave->master  buzzer drive
//   busy       slave->master  a sound is in an on or off phase
//   active_id  slave->master  id being played, holds when idle
//   done[3:0]  slave->master  completion pulse per id
//   abort[3:0] slave->master  preemption pulse per id

interface beep_sched_if;
    logic       mute;
    logic [3:0] req;
    logic       beep;
    logic       busy;
    logic [1:0] active_id;
    logic [3:0] done;
    logic [3:0] abort;

    modport master (
        output mute, req,
        input  beep, busy, active_id, done, abort
    );

    modport slave (
        input  mute, req,
        output beep, busy, active_id, done, abort
    );
endinterface

// File: rtl/beep_sched.sv
// rtl/beep_sched.sv - priority arbiter and burst sequencer for the shared board buzzer
//
// Purpose: latches request pulses from four sound sources (0 key click,
// 1 timeout, 2 wrong guess, 3 victory), grants the highest pending id, and
// plays it as a square-wave tone gated into timed on/off bursts. A higher id
// pending while a sound plays preempts it immediately.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  beep_sched_if.slave: mute, req in; beep, busy, active_id, done, abort out
// Timing parameters are packed per id: HALF_PER[16k+:16], ON_TICKS[8k+:8],
// OFF_TICKS[8k+:8], BURSTS[4k+:4]; zero half-period/on/bursts read as one.

module beep_sched #(
    parameter int          TICK_DIV  = 50000,
    parameter logic [63:0] HALF_PER  = {16'd12500, 16'd25000, 16'd50000, 16'd20000},
    parameter logic [31:0] ON_TICKS  = {8'd150, 8'd200, 8'd250, 8'd30},
    parameter logic [31:0] OFF_TICKS = {8'd100, 8'd50, 8'd50, 8'd0},
    parameter logic [15:0] BURSTS    = {4'd3, 4'd2, 4'd1, 4'd1}
) (
    input  logic clk,
    input  logic rst,
    beep_sched_if.slave bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

    state_t        state_q, state_d;
    logic [3:0]    pending_q, pending_d;
    logic          beep_q, beep_d;
    logic          busy_q, busy_d;
    logic [1:0]    active_id_q, active_id_d;
    logic [3:0]    done_q, done_d;
    logic [3:0]    abort_q, abort_d;
    logic [3:0]    burst_q, burst_d;
    logic [15:0]   tone_q, tone_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [7:0]    phase_q, phase_d;

    logic [15:0] hp_len;
    logic [7:0]  on_len;
    logic [7:0]  off_len;
    logic [3:0]  bursts_n;
    logic        grant_any;
    logic [1:0]  grant_id;
    logic        preempt;
    logic [3:0]  ign_mask;
    logic        tick_wrap;

    always_comb begin
        // Per-id timing for the sound currently owning the buzzer.
        hp_len   = HALF_PER[{active_id_q, 4'b0000} +: 16];
        on_len   = ON_TICKS[{active_id_q, 3'b000} +: 8];
        off_len  = OFF_TICKS[{active_id_q, 3'b000} +: 8];
        bursts_n = BURSTS[{active_id_q, 2'b00} +: 4];
        if (hp_len == 16'd0)  hp_len = 16'd1;
        if (on_len == 8'd0)   on_len = 8'd1;
        if (bursts_n == 4'd0) bursts_n = 4'd1;

        grant_any = |pending_q;
        if (pending_q[3])      grant_id = 2'd3;
        else if (pending_q[2]) grant_id = 2'd2;
        else if (pending_q[1]) grant_id = 2'd1;
        else                   grant_id = 2'd0;

        preempt   = busy_q && grant_any && (grant_id > active_id_q);
        // A retrigger of the sound already playing is dropped, not queued.
        ign_mask  = busy_q ? (4'b0001 << active_id_q) : 4'b0000;
        tick_wrap = (tick_q == TW'(TICK_DIV - 1));

        state_d     = state_q;
        pending_d   = pending_q;
        beep_d      = beep_q;
        busy_d      = busy_q;
        active_id_d = active_id_q;
        done_d      = 4'b0000;
        abort_d     = 4'b0000;
        burst_d     = burst_q;
        tone_d      = tone_q;
        tick_d      = tick_q;
        phase_d     = phase_q;

        if (bus.mute) begin
            state_d   = S_IDLE;
            pending_d = 4'b0000;
            beep_d    = 1'b0;
            busy_d    = 1'b0;
            burst_d   = 4'd0;
            tone_d    = 16'd0;
            tick_d    = '0;
            phase_d   = 8'd0;
        end else begin
            pending_d = pending_q | (bus.req & ~ign_mask);
            if (((state_q == S_IDLE) && grant_any) || preempt) begin
                if (preempt) abort_d[active_id_q] = 1'b1;
                pending_d[grant_id] = 1'b0;
                state_d     = S_ON;
                beep_d      = 1'b1;
                busy_d      = 1'b1;
                active_id_d = grant_id;
                burst_d     = 4'd1;
                tone_d      = 16'd0;
                tick_d      = '0;
                phase_d     = 8'd0;
            end else begin
                case (state_q)
                    S_ON: begin
                        if (tick_wrap && (phase_q == on_len - 8'd1)) begin
                            // Every phase restarts its tick count from zero.
                            tick_d  = '0;
                            phase_d = 8'd0;
                            tone_d  = 16'd0;
                            if (burst_q < bursts_n) begin
                                if (off_len != 8'd0) begin
                                    state_d = S_OFF;
                                    beep_d  = 1'b0;
                                end else begin
                                    burst_d = burst_q + 4'd1;
                                    beep_d  = 1'b1;
                                end
                            end else begin
                                state_d = S_IDLE;
                                beep_d  = 1'b0;
                                busy_d  = 1'b0;
                                done_d[active_id_q] = 1'b1;
                            end
                        end else begin
                            if (tick_wrap) begin
                                tick_d  = '0;
                                phase_d = phase_q + 8'd1;
                            end else begin
                                tick_d = tick_q + TW'(1);
                            end
                            if (tone_q == hp_len - 16'd1) begin
                                beep_d = ~beep_q;
                                tone_d = 16'd0;
                            end else begin
                                tone_d = tone_q + 16'd1;
                            end
                        end
                    end
                    S_OFF: begin
                        if (tick_wrap && (phase_q == off_len - 8'd1)) begin
                            state_d = S_ON;
                            burst_d = burst_q + 4'd1;
                            beep_d  = 1'b1;
                            tone_d  = 16'd0;
                            tick_d  = '0;
                            phase_d = 8'd0;
                        end else if (tick_wrap) begin
                            tick_d  = '0;
                            phase_d = phase_q + 8'd1;
                        end else begin
                            tick_d = tick_q + TW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pending_q   <= 4'b0000;
            beep_q      <= 1'b0;
            busy_q      <= 1'b0;
            active_id_q <= 2'd0;
            done_q      <= 4'b0000;
            abort_q     <= 4'b0000;
            burst_q     <= 4'd0;
            tone_q      <= 16'd0;
            tick_q      <= '0;
            phase_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            beep_q      <= beep_d;
            busy_q      <= busy_d;
            active_id_q <= active_id_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            burst_q     <= burst_d;
            tone_q      <= tone_d;
            tick_q      <= tick_d;
            phase_q     <= phase_d;
        end
    end

    assign bus.beep      = beep_q;
    assign bus.busy      = busy_q;
    assign bus.active_id = active_id_q;
    assign bus.done      = done_q;
    assign bus.abort     = abort_q;

endmodule

// File: doc/beep_sched.md
Name: beep_sched

Overview:
- Arbiter and sequencer for the single board buzzer, shared by four sound requesters:
  - id0 key click
  - id1 timeout
  - id2 wrong guess
  - id3 victory
- Latches one-cycle request pulses from the game FSM and grants the highest-priority pending sound. Higher-priority requests preempt the sound that is playing.
- Generates the tone as a square wave and shapes it into timed on/off bursts.
- Sits between the game-state controller and the beep pin, replacing per-state beep enables.

Parameters:
- TICK_DIV, 50000: clk cycles per timing tick (1 ms at 50 MHz).
- HALF_PER, {16'd12500,16'd25000,16'd50000,16'd20000}: packed 4x16 tone half-periods in clk cycles, index [16*k+:16] for id k. A value of 0 is treated as 1.
- ON_TICKS, {8'd150,8'd200,8'd250,8'd30}: packed 4x8 burst on-length in ticks. A value of 0 is treated as 1.
- OFF_TICKS, {8'd100,8'd50,8'd50,8'd0}: packed 4x8 gap length between bursts, in ticks.
- BURSTS, {4'd3,4'd2,4'd1,4'd1}: packed 4x4 on-phases per sound. A value of 0 is treated as 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- mute  in  1  synchronous silence/flush; mirrors game-enable low
- req  in  4  request pulses, bit k = id k; level-sampled each edge
- beep  out  1  buzzer drive, registered
- busy  out  1  high while in ON or OFF
- active_id  out  2  id being played; holds last value when idle
- done  out  4  one-cycle pulse, bit k = id k completed all bursts
- abort  out  4  one-cycle pulse, bit k = id k preempted

Behaviour:
- Reset (rst=1 at an edge):
  - state IDLE, pending=0, all counters 0.
  - beep=0, busy=0, active_id=0, done=0, abort=0.
  - rst has priority over mute and req.
- mute=1 at an edge:
  - same clearing as rst, except active_id holds.
  - req is ignored; no done/abort pulses.
- Pending:
  - pending[k] is set at any edge where req[k]=1, except when k equals active_id while busy (ignored).
  - A repeat request for an already-pending id has no extra effect.
  - pending[k] is cleared at the edge that grants k.
- Priority: fixed, id3 > id2 > id1 > id0.
- State IDLE:
  - At an edge with any pending bit set, grant the highest id.
  - state←ON, beep←1, busy←1, active_id←id.
  - burst count←1, tone counter←0, tick counter←0, tick-phase counter←0.
  - Request-to-beep latency: req sampled at edge n → pending at n → beep=1 after edge n+1.
- State ON:
  - Tone counter counts clk. When it reaches HALF_PER[id]-1, beep toggles and the counter resets.
  - The phase lasts exactly ON_TICKS[id]*TICK_DIV cycles. The tick counter restarts at every phase start, so there is no alignment jitter.
  - On phase end, if burst count < BURSTS[id] and OFF_TICKS[id]>0: state←OFF, beep←0.
  - On phase end, if burst count < BURSTS[id] and OFF_TICKS=0: stay ON, burst count+1, tone restarts with beep←1.
  - On phase end, if burst count = BURSTS[id]: state←IDLE, beep←0, busy←0, done[id] pulses for that cycle.
- State OFF:
  - beep=0 for exactly OFF_TICKS[id]*TICK_DIV cycles.
  - Then state←ON, burst count+1, beep←1, tone counter←0.
- Preemption:
  - Applies in ON or OFF when any pending id is greater than active_id.
  - At the next edge, abort[old] pulses and the new id is granted exactly as from IDLE (beep←1).
  - The old sound is dropped, not resumed; no done pulse is issued for it.
- Lower- or equal-priority pending ids wait. After done, the controller spends at least one IDLE cycle (beep=0) before the next grant.
- Simultaneous events:
  - Completion and a new req on the same edge: done pulses, the req is latched, and the grant follows at the next edge.
  - Multiple req bits on one edge: all are latched and served in priority order.
- Counter widths: tick counter ≥ clog2(TICK_DIV); phase counter 8 bits; tone counter 16 bits. No counter overflows at maximum parameter values.

Test Plan:
- Setup: TICK_DIV=4; id0: HP=2, ON=2, OFF=1, BURSTS=1; id3: HP=1, ON=2, OFF=1, BURSTS=3.
- Reset: assert rst 3 cycles while req=4'hF → beep=0, busy=0, done=0, abort=0, pending empty; first grant occurs only after req is re-pulsed.
- Single id0: req=0001 at edge 10 → beep=1 from edge 11, toggling every 2 cycles for 8 cycles (1,1,0,0,1,1,0,0); done[0] high for 1 cycle after edge 19; busy low after edge 19.
- Victory id3: req=1000 → three 8-cycle ON windows toggling every cycle, separated by 4-cycle beep=0 gaps; total busy window 32 cycles; a single done[3] pulse at the end.
- Preemption: id0 playing; req=1000 at cycle 3 of ON → abort[0] pulse at the next edge; beep restarts at 1 for id3 with active_id=3; id0 is never completed, and no done[0] ever occurs.
- Queueing: req=0101 on one edge → id2 plays fully, then done[2], then one IDLE cycle, then id0 plays; a req=0100 pulse during id2 is ignored (id2 plays only once).
- Mute: mute=1 mid-OFF with id1 pending → beep=0, busy=0 next cycle, pending cleared; after mute=0 no sound starts without a new req.
